// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller: FSM states, opcodes,
// mux select encodings and halt causes.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } ctrl_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Instruction fetches are always full words.
  localparam logic [2:0] FETCH_SIZE = 3'b010;

  typedef enum logic [1:0] {
    PC_PLUS4   = 2'b00,
    PC_IMM     = 2'b01,
    PC_RS1_IMM = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_MISALIGN = 2'b11
  } err_e;

  function automatic logic is_exec_op(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Memory wait watchdog: down-counter reloaded on clear, expired at terminal
// count zero. LIMIT=0 disables expiry entirely.
module mem_timeout_ctr #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LOAD = (LIMIT == 0) ? '0 : CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (LIMIT != 0) && (cnt == '0);

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control FSM (fetch/decode/execute/memory/writeback).
// Optional perf counters (cycle_cnt, instret_cnt) with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter logic [1:0]  RESET_PC_SEL = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        branch_taken,
  input  logic        addr_misaligned,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic [2:0]  mem_size,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        halt,
  output logic [1:0]  err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  // state  | meaning
  // IDLE   | waiting for start
  // FETCH  | instruction read on the memory port, latch IR on ready
  // DECODE | classify opcode, trap SYSTEM / illegal
  // EXEC   | ALU op; branches resolve here, loads/stores check alignment
  // MEM    | data access on the memory port
  // WB     | register file write and PC update
  // HALT   | stopped with cause in err until reset

  ctrl_state_e state_q, state_d;
  err_e        err_q, err_d;
  logic        tmo_wait, tmo_clr, tmo_en, tmo_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Counter runs only while a request is stalled; any state change reloads it.
  assign tmo_wait = (state_q == FETCH) || (state_q == MEM);
  assign tmo_en   = tmo_wait && !mem_ready;
  assign tmo_clr  = !tmo_en || (state_d != state_q);

  mem_timeout_ctr #(
    .LIMIT (MEM_TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_is_fetch = 1'b0;
    mem_size     = 3'b000;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    alu_a_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_ALU;
    halt         = 1'b0;
    case (state_q)
      IDLE: begin
        pc_sel = RESET_PC_SEL;
        if (start) state_d = FETCH;
      end
      FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        mem_size     = FETCH_SIZE;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (tmo_expired) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        if (opcode == OP_SYSTEM) begin
          state_d = HALT;
          err_d   = ERR_NONE;
        end else if (!is_exec_op(opcode)) begin
          state_d = HALT;
          err_d   = ERR_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          if (addr_misaligned) begin
            state_d = HALT;
            err_d   = ERR_MISALIGN;
          end else begin
            state_d = MEM;
          end
        end else if (opcode == OP_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
          state_d = FETCH;
        end else begin
          alu_a_sel = (opcode == OP_AUIPC);
          state_d   = WB;
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = (opcode == OP_STORE);
        mem_size = funct3;
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (tmo_expired) begin
          state_d = HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = FETCH;
        case (opcode)
          OP_LOAD: wb_sel = WB_MEM;
          OP_LUI:  wb_sel = WB_IMM;
          OP_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_IMM;
          end
          OP_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_RS1_IMM;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state = state_q;
  assign err   = err_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if ((state_q != IDLE) && (state_q != HALT)) cycle_cnt <= cycle_cnt + 32'd1;
      if (pc_we) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector tables with a
// scoreboard queue, plus a hand-written reset-during-store sequence.
module tb_multicycle_ctrl;

  localparam int unsigned TMO = 4;
  localparam logic [1:0]  RPS = 2'b00;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXE = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [6:0] O_R = 7'b0110011, O_IMM = 7'b0010011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_BR = 7'b1100011, O_LUI = 7'b0110111,
                         O_AUIPC = 7'b0010111, O_JAL = 7'b1101111, O_JALR = 7'b1100111,
                         O_SYS = 7'b1110011, O_BAD = 7'b1111111;

  typedef struct packed {
    logic       s;
    logic [6:0] op;
    logic [2:0] f3;
    logic       bt;
    logic       mis;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       fe;
    logic [2:0] sz;
    logic       ir;
    logic       pw;
    logic [1:0] ps;
    logic       as;
    logic       rw;
    logic [1:0] ws;
    logic       h;
    logic [1:0] e;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct packed {
    logic [6:0] op;
    logic       as;
    logic [1:0] ws;
    logic [1:0] ps;
  } alu_row_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       branch_taken = 1'b0;
  logic       addr_misaligned = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_is_fetch, ir_we, pc_we, alu_a_sel, rf_we, halt;
  logic [2:0] mem_size, state;
  logic [1:0] pc_sel, wb_sel, err;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl #(
    .MEM_TIMEOUT  (TMO),
    .RESET_PC_SEL (RPS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .opcode          (opcode),
    .funct3          (funct3),
    .branch_taken    (branch_taken),
    .addr_misaligned (addr_misaligned),
    .mem_ready       (mem_ready),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_is_fetch    (mem_is_fetch),
    .mem_size        (mem_size),
    .ir_we           (ir_we),
    .pc_we           (pc_we),
    .pc_sel          (pc_sel),
    .alu_a_sel       (alu_a_sel),
    .rf_we           (rf_we),
    .wb_sel          (wb_sel),
    .state           (state),
    .halt            (halt),
    .err             (err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt       (cycle_cnt),
    .instret_cnt     (instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  vec_t tbl[$];
  out_t sb[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic in_t ii(logic s, logic [6:0] op, logic [2:0] f3,
                             logic bt, logic mis, logic rdy);
    in_t r;
    r.s = s; r.op = op; r.f3 = f3; r.bt = bt; r.mis = mis; r.rdy = rdy;
    return r;
  endfunction

  function automatic out_t oz(logic [2:0] st);
    out_t r = '0;
    r.st = st;
    if (st == S_IDLE) r.ps = RPS;
    return r;
  endfunction

  function automatic out_t ofetch(logic ir);
    out_t r = oz(S_FETCH);
    r.req = 1'b1; r.fe = 1'b1; r.sz = 3'b010; r.ir = ir;
    return r;
  endfunction

  function automatic out_t omem(logic we, logic [2:0] sz);
    out_t r = oz(S_MEM);
    r.req = 1'b1; r.we = we; r.sz = sz;
    return r;
  endfunction

  function automatic out_t ohalt(logic [1:0] e);
    out_t r = oz(S_HALT);
    r.h = 1'b1; r.e = e;
    return r;
  endfunction

  task automatic add(in_t i, out_t o);
    vec_t v;
    v.i = i; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(in_t i);
    start = i.s; opcode = i.op; funct3 = i.f3;
    branch_taken = i.bt; addr_misaligned = i.mis; mem_ready = i.rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0);
    @(posedge clk);
    @(negedge clk);
    chk("reset.state", 32'(state), 32'(S_IDLE));
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.pc_sel", 32'(pc_sel), 32'(RPS));
    chk("reset.halt_err", 32'({halt, err}), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic run_table(string name);
    out_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].i);
      sb.push_back(tbl[i].o);
      @(negedge clk);
      if (sb.size() == 0) begin
        chk($sformatf("%s[%0d].scoreboard_empty", name, i), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("%s[%0d].state", name, i), 32'(state), 32'(e.st));
        chk($sformatf("%s[%0d].mem_req", name, i), 32'(mem_req), 32'(e.req));
        chk($sformatf("%s[%0d].mem_we", name, i), 32'(mem_we), 32'(e.we));
        chk($sformatf("%s[%0d].mem_is_fetch", name, i), 32'(mem_is_fetch), 32'(e.fe));
        chk($sformatf("%s[%0d].mem_size", name, i), 32'(mem_size), 32'(e.sz));
        chk($sformatf("%s[%0d].ir_we", name, i), 32'(ir_we), 32'(e.ir));
        chk($sformatf("%s[%0d].pc_we", name, i), 32'(pc_we), 32'(e.pw));
        chk($sformatf("%s[%0d].pc_sel", name, i), 32'(pc_sel), 32'(e.ps));
        chk($sformatf("%s[%0d].alu_a_sel", name, i), 32'(alu_a_sel), 32'(e.as));
        chk($sformatf("%s[%0d].rf_we", name, i), 32'(rf_we), 32'(e.rw));
        chk($sformatf("%s[%0d].wb_sel", name, i), 32'(wb_sel), 32'(e.ws));
        chk($sformatf("%s[%0d].halt", name, i), 32'(halt), 32'(e.h));
        chk($sformatf("%s[%0d].err", name, i), 32'(err), 32'(e.e));
      end
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_row_t rows[6];
    out_t     o;

    rows[0] = '{O_R,     1'b0, 2'b00, 2'b00};
    rows[1] = '{O_IMM,   1'b0, 2'b00, 2'b00};
    rows[2] = '{O_AUIPC, 1'b1, 2'b00, 2'b00};
    rows[3] = '{O_LUI,   1'b0, 2'b11, 2'b00};
    rows[4] = '{O_JAL,   1'b0, 2'b10, 2'b01};
    rows[5] = '{O_JALR,  1'b0, 2'b10, 2'b10};

    // ALU / U / J ops with single-cycle memory: writeback in cycle 4
    for (int r = 0; r < 6; r++) begin
      do_reset();
      add(ii(1, rows[r].op, 3'd0, 0, 0, 0), oz(S_IDLE));
      add(ii(0, rows[r].op, 3'd0, 0, 0, 1), ofetch(1));
      add(ii(0, rows[r].op, 3'd0, 0, 0, 0), oz(S_DEC));
      o = oz(S_EXE); o.as = rows[r].as;
      add(ii(0, rows[r].op, 3'd0, 0, 0, 0), o);
      o = oz(S_WB); o.rw = 1; o.pw = 1; o.ws = rows[r].ws; o.ps = rows[r].ps;
      add(ii(0, rows[r].op, 3'd0, 0, 0, 0), o);
      add(ii(0, rows[r].op, 3'd0, 0, 0, 0), ofetch(0));
      run_table($sformatf("alu_op%0d", r));
`ifdef MULTICYCLE_CTRL_PERF_EN
      chk("perf_alu.cycle_cnt", cycle_cnt, 32'd4);
      chk("perf_alu.instret_cnt", instret_cnt, 32'd1);
`endif
    end

    // Load with a three-cycle memory wait
    do_reset();
    add(ii(1, O_LD, 3'b010, 0, 0, 0), oz(S_IDLE));
    add(ii(0, O_LD, 3'b010, 0, 0, 1), ofetch(1));
    add(ii(0, O_LD, 3'b010, 0, 0, 0), oz(S_DEC));
    add(ii(0, O_LD, 3'b010, 0, 0, 0), oz(S_EXE));
    add(ii(0, O_LD, 3'b010, 0, 0, 0), omem(0, 3'b010));
    add(ii(0, O_LD, 3'b010, 0, 0, 0), omem(0, 3'b010));
    add(ii(0, O_LD, 3'b010, 0, 0, 1), omem(0, 3'b010));
    o = oz(S_WB); o.rw = 1; o.pw = 1; o.ws = 2'b01;
    add(ii(0, O_LD, 3'b010, 0, 0, 0), o);
    add(ii(0, O_LD, 3'b010, 0, 0, 0), ofetch(0));
    run_table("load_wait");

    // Halfword store, single-cycle memory
    do_reset();
    add(ii(1, O_ST, 3'b001, 0, 0, 0), oz(S_IDLE));
    add(ii(0, O_ST, 3'b001, 0, 0, 1), ofetch(1));
    add(ii(0, O_ST, 3'b001, 0, 0, 0), oz(S_DEC));
    add(ii(0, O_ST, 3'b001, 0, 0, 0), oz(S_EXE));
    o = omem(1, 3'b001); o.pw = 1;
    add(ii(0, O_ST, 3'b001, 0, 0, 1), o);
    add(ii(0, O_ST, 3'b001, 0, 0, 0), ofetch(0));
    run_table("store");

    // Branch taken / not taken; stray mem_ready in DECODE/EXEC is ignored
    for (int bt = 0; bt < 2; bt++) begin
      do_reset();
      add(ii(1, O_BR, 3'd0, bt[0], 0, 0), oz(S_IDLE));
      add(ii(0, O_BR, 3'd0, bt[0], 0, 1), ofetch(1));
      add(ii(0, O_BR, 3'd0, bt[0], 0, 1), oz(S_DEC));
      o = oz(S_EXE); o.pw = 1; o.ps = bt[0] ? 2'b01 : 2'b00;
      add(ii(0, O_BR, 3'd0, bt[0], 0, 1), o);
      add(ii(0, O_BR, 3'd0, bt[0], 0, 0), ofetch(0));
      run_table($sformatf("branch_bt%0d", bt));
    end

    // Illegal opcode, later start and ready ignored
    do_reset();
    add(ii(1, O_BAD, 3'd0, 0, 0, 0), oz(S_IDLE));
    add(ii(0, O_BAD, 3'd0, 0, 0, 1), ofetch(1));
    add(ii(0, O_BAD, 3'd0, 0, 0, 0), oz(S_DEC));
    add(ii(0, O_BAD, 3'd0, 0, 0, 0), ohalt(2'b10));
    add(ii(1, O_BAD, 3'd0, 0, 0, 1), ohalt(2'b10));
    add(ii(1, O_R,   3'd0, 0, 0, 1), ohalt(2'b10));
    run_table("illegal");

    // Misaligned store never reaches the memory port
    do_reset();
    add(ii(1, O_ST, 3'b010, 0, 1, 0), oz(S_IDLE));
    add(ii(0, O_ST, 3'b010, 0, 1, 1), ofetch(1));
    add(ii(0, O_ST, 3'b010, 0, 1, 0), oz(S_DEC));
    add(ii(0, O_ST, 3'b010, 0, 1, 0), oz(S_EXE));
    add(ii(0, O_ST, 3'b010, 0, 1, 1), ohalt(2'b11));
    add(ii(1, O_ST, 3'b010, 0, 0, 1), ohalt(2'b11));
    run_table("misaligned");

    // ECALL: clean halt
    do_reset();
    add(ii(1, O_SYS, 3'd0, 0, 0, 0), oz(S_IDLE));
    add(ii(0, O_SYS, 3'd0, 0, 0, 1), ofetch(1));
    add(ii(0, O_SYS, 3'd0, 0, 0, 0), oz(S_DEC));
    add(ii(0, O_SYS, 3'd0, 0, 0, 0), ohalt(2'b00));
    add(ii(1, O_SYS, 3'd0, 0, 0, 1), ohalt(2'b00));
    run_table("ecall");

    // Fetch timeout: exactly TMO stalled FETCH cycles
    do_reset();
    add(ii(1, O_R, 3'd0, 0, 0, 0), oz(S_IDLE));
    for (int c = 0; c < 4; c++) add(ii(0, O_R, 3'd0, 0, 0, 0), ofetch(0));
    add(ii(0, O_R, 3'd0, 0, 0, 0), ohalt(2'b01));
    add(ii(1, O_R, 3'd0, 0, 0, 1), ohalt(2'b01));
    run_table("fetch_timeout");

    // Data timeout: byte load with memory never ready
    do_reset();
    add(ii(1, O_LD, 3'b000, 0, 0, 0), oz(S_IDLE));
    add(ii(0, O_LD, 3'b000, 0, 0, 1), ofetch(1));
    add(ii(0, O_LD, 3'b000, 0, 0, 0), oz(S_DEC));
    add(ii(0, O_LD, 3'b000, 0, 0, 0), oz(S_EXE));
    for (int c = 0; c < 4; c++) add(ii(0, O_LD, 3'b000, 0, 0, 0), omem(0, 3'b000));
    add(ii(0, O_LD, 3'b000, 0, 0, 0), ohalt(2'b01));
    run_table("mem_timeout");

    // Reset asserted while a store is on the memory port
    do_reset();
    add(ii(1, O_ST, 3'b010, 0, 0, 0), oz(S_IDLE));
    add(ii(0, O_ST, 3'b010, 0, 0, 1), ofetch(1));
    add(ii(0, O_ST, 3'b010, 0, 0, 0), oz(S_DEC));
    add(ii(0, O_ST, 3'b010, 0, 0, 0), oz(S_EXE));
    add(ii(0, O_ST, 3'b010, 0, 0, 0), omem(1, 3'b010));
    run_table("store_pre_reset");
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_pre_reset.cycle_cnt", cycle_cnt, 32'd3);
    chk("perf_pre_reset.instret_cnt", instret_cnt, 32'd0);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset.mem_req", 32'(mem_req), 32'd0);
    chk("mid_reset.mem_we", 32'(mem_we), 32'd0);
    chk("mid_reset.state", 32'(state), 32'(S_IDLE));
    chk("mid_reset.pc_we", 32'(pc_we), 32'd0);
    chk("mid_reset.rf_we", 32'(rf_we), 32'd0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("mid_reset.cycle_cnt", cycle_cnt, 32'd0);
    chk("mid_reset.instret_cnt", instret_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences the instruction cycle: fetch, decode, execute, memory, writeback.
- Drives enables and muxes for the IR, PC, register file, ALU and unified memory port, using the opcode/funct3 from the instruction decoder plus branch and alignment status from the datapath.
- Stops the core on ECALL/EBREAK, unrecognized opcodes, misaligned accesses and memory timeouts.

Parameters:
- MEM_TIMEOUT, 255, max cycles a memory request may wait for mem_ready before HALT with err=01; 0 disables the timeout.
- RESET_PC_SEL, 0, value of pc_sel while in IDLE (kept for boot-vector mux compatibility).

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  leave IDLE and begin fetching
- opcode  input  7  decoded opcode, valid from DECODE onward (from IR via decoder)
- funct3  input  3  decoded funct3, used for load/store width passthrough
- branch_taken  input  1  comparator result for the current branch
- addr_misaligned  input  1  effective address misaligned for funct3 width
- mem_ready  input  1  memory completes request this cycle
- mem_req  output  1  memory request valid
- mem_we  output  1  store request
- mem_is_fetch  output  1  request is an instruction fetch
- mem_size  output  3  funct3 passthrough for data accesses, 3'b010 for fetch
- ir_we  output  1  latch fetched instruction
- pc_we  output  1  update PC
- pc_sel  output  2  00 pc+4, 01 pc+imm (branch/JAL), 10 rs1+imm (JALR)
- alu_a_sel  output  1  0 rs1, 1 pc (AUIPC)
- rf_we  output  1  register file write
- wb_sel  output  2  00 alu, 01 mem data, 10 pc+4, 11 imm (LUI)
- state  output  3  current state encoding, for debug
- halt  output  1  core stopped, sticky until reset
- err  output  2  00 clean halt (ECALL/EBREAK), 01 mem timeout, 10 illegal opcode, 11 misaligned

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except pc_sel=RESET_PC_SEL and state=IDLE encoding.
  - Timeout counter cleared.
  - Reset mid-request drops mem_req in the same cycle. No partial writeback; pc/rf enables go low immediately.
- Outputs are combinational from the registered state, opcode and handshake inputs. Enables are single-cycle pulses.
- IDLE: wait for start=1, then go to FETCH next cycle.
- FETCH:
  - mem_req=1, mem_is_fetch=1, mem_we=0.
  - On mem_ready: ir_we=1, go to DECODE.
  - Each cycle without mem_ready increments the counter. When counter==MEM_TIMEOUT-1 and no ready: go to HALT, err=01.
- DECODE (1 cycle):
  - opcode 1110011: HALT, err=00.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111}: HALT, err=10.
  - Otherwise go to EXEC.
- EXEC:
  - Load/store: if addr_misaligned, go to HALT with err=11; otherwise go to MEM.
  - Branch: pc_we=1, pc_sel=branch_taken?01:00, go to FETCH.
  - All other opcodes: go to WB. alu_a_sel=1 only for AUIPC.
- MEM:
  - mem_req=1, mem_we=store, mem_size=funct3. Same timeout rule as FETCH.
  - On mem_ready, store: pc_we=1, pc_sel=00, go to FETCH.
  - On mem_ready, load: go to WB.
- WB:
  - rf_we=1, pc_we=1.
  - wb_sel: 01 for load, 10 for JAL/JALR, 11 for LUI, else 00.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
  - Go to FETCH.
- HALT:
  - halt=1, err held.
  - start ignored; all enables 0. Exit only via reset.
- Timeout counter clears on every state entry and on mem_ready.
- mem_ready outside FETCH/MEM is ignored.
- Latency with 1-cycle memory: ALU/U/J ops 4 cycles, branch and store 3/4 cycles, load 5 cycles.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined, two additional outputs are added:
  - cycle_cnt (32): increments every non-IDLE, non-HALT cycle.
  - instret_cnt (32): increments on each retiring pc_we pulse.
  - Both reset to 0 and wrap at 2^32.
- Without the macro these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - ctrl_state_e (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6).
  - RV32I opcode localparams.
  - pc_sel_e, wb_sel_e and err_e enums.
- One sub-module, mem_timeout_ctr: parameterised counter with clear, enable and expired output, instantiated once.

Test Plan:
- R-type: reset, start=1, opcode=0110011, mem_ready on first FETCH cycle → ir_we at cycle 1; rf_we=1, wb_sel=00, pc_we=1, pc_sel=00 at cycle 4; back in FETCH at cycle 5.
- Load with 3-cycle memory wait: opcode=0000011, funct3=010 → MEM holds mem_req=1, mem_we=0 for 3 cycles; then WB with rf_we=1, wb_sel=01.
- Branch taken and not taken: opcode=1100011 → pc_sel=01 when branch_taken=1 and 00 when 0, in EXEC; rf_we never asserted.
- Errors:
  - Illegal opcode 1111111 → halt=1, err=10 after DECODE.
  - Store with addr_misaligned=1 → err=11, no mem_we.
  - ECALL → err=00.
  - A later start has no effect.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 in FETCH → HALT, err=01 after exactly 4 FETCH cycles, mem_req deasserted.
- Reset mid-MEM store: rst_n=0 while mem_req=1, mem_we=1 → both drop to 0 immediately, state=IDLE. With MULTICYCLE_CTRL_PERF_EN, cycle_cnt=0 and instret_cnt=0.
